// File: rtl/msg_crypt_pkg.sv
// ----------------------------------------------------------------------------
// msg_crypt_pkg
// Shared definitions for the message decrypt engine:
//   - LFSR_PTRN : the nine candidate 7-bit LFSR tap patterns, in priority order
//   - SPACE     : ASCII space, the known preamble/pad character
//   - PERR_BYTE : byte written in place of a parity-failing message byte
//   - state_e   : decrypt FSM states
//   - lfsr_step : one shift of the 7-bit Fibonacci LFSR
// ----------------------------------------------------------------------------
package msg_crypt_pkg;

  localparam int         NUM_PTRN  = 9;
  localparam logic [7:0] SPACE     = 8'h20;
  localparam logic [7:0] PERR_BYTE = 8'h80;

  localparam logic [6:0] LFSR_PTRN [NUM_PTRN] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_MATCH  = 3'd2,
    ST_DECODE = 3'd3,
    ST_PAD    = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Shift left by one; the new LSB is the XOR of the tapped bits.
  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] p);
    return {s[5:0], ^(s & p)};
  endfunction

endpackage

// File: rtl/lfsr_tap_matcher.sv
// ----------------------------------------------------------------------------
// lfsr_tap_matcher
// Combinational search for the tap pattern that explains an 8-entry run of
// consecutive LFSR states. State s[i] lives at state_buf_i[7*i +: 7].
// A pattern fits when every s[i+1] is lfsr_step(s[i], pattern) for i = 0..6.
// The lowest-index fitting pattern wins.
//
// Ports:
//   state_buf_i   in  56  eight 7-bit recovered LFSR states, s[0] in the LSBs
//   match_valid_o out  1  at least one pattern fits
//   match_idx_o   out  4  index into LFSR_PTRN of the selected pattern
// ----------------------------------------------------------------------------
module lfsr_tap_matcher
  import msg_crypt_pkg::*;
(
  input  logic [55:0] state_buf_i,
  output logic        match_valid_o,
  output logic [3:0]  match_idx_o
);

  logic [NUM_PTRN-1:0] fit;

  always_comb begin
    fit = '1;
    for (int p = 0; p < NUM_PTRN; p++) begin
      for (int i = 0; i < 7; i++) begin
        if (state_buf_i[(i+1)*7 +: 7] != lfsr_step(state_buf_i[i*7 +: 7], LFSR_PTRN[p])) begin
          fit[p] = 1'b0;
        end
      end
    end
  end

  // Scan from the top so the lowest fitting index is the last one written.
  always_comb begin
    match_valid_o = 1'b0;
    match_idx_o   = 4'd0;
    for (int p = NUM_PTRN - 1; p >= 0; p--) begin
      if (fit[p]) begin
        match_valid_o = 1'b1;
        match_idx_o   = 4'(p);
      end
    end
  end

endmodule

// File: rtl/msg_decrypt_engine.sv
// ----------------------------------------------------------------------------
// msg_decrypt_engine
// Reads a 64-byte encrypted message from data memory, recovers the LFSR tap
// pattern and seed from the all-space preamble, decrypts the message, drops
// the leading spaces (up to MAX_STRIP) and writes 64 plaintext bytes back,
// space-padded at the end.
//
// Launch handshake: Start high parks the block in IDLE; a 1->0 transition
// launches a run. Ack is high in DONE; raising Start leaves DONE.
//
// Ports:
//   Clk          in   1  clock, rising edge
//   Reset        in   1  asynchronous, active-high
//   Start        in   1  launch control (falling transition launches)
//   Ack          out  1  run finished
//   rd_addr      out  8  read address; memory returns data one cycle later
//   rd_data      in   8  read data
//   wr_en        out  1  write strobe (combinational, same cycle as data)
//   wr_addr      out  8  write address
//   wr_data      out  8  write data
//   no_match     out  1  no tap pattern fits the preamble (sticky per run)
//   par_err_cnt  out  6  parity-failing message bytes, saturating
//   dbg_state    out  3  current FSM state
//
// Build option: PARITY_CHECK_EN enables per-byte even-parity checking on
// bit 7. Without it bit 7 is ignored and par_err_cnt stays 0.
//
// Read/write handshake: the memory has independent read and write ports.
// A read address presented in cycle N yields rd_data in cycle N+1. A write
// happens in any cycle where wr_en is high, using wr_addr/wr_data of that
// same cycle; there is no back-pressure on either port.
// ----------------------------------------------------------------------------
module msg_decrypt_engine
  import msg_crypt_pkg::*;
#(
  parameter logic [7:0] MSG_BASE  = 8'd64,
  parameter logic [7:0] OUT_BASE  = 8'd0,
  parameter logic [5:0] MAX_STRIP = 6'd63
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       no_match,
  output logic [5:0] par_err_cnt,
  output logic [2:0] dbg_state
);

  state_e      state_q, state_d;
  logic        start_q;
  logic [6:0]  cnt_q, cnt_d;            // LOAD: 0..8, DECODE: 0..64
  logic [7:0]  rd_addr_q, rd_addr_d;
  logic [55:0] sbuf_q, sbuf_d;          // recovered LFSR states s[0..7]
  logic [6:0]  lfsr_q, lfsr_d;
  logic [6:0]  ptrn_q, ptrn_d;
  logic        strip_q, strip_d;
  logic [5:0]  strip_cnt_q, strip_cnt_d;
  logic [6:0]  wr_ptr_q, wr_ptr_d;      // 0..64, never wraps
  logic        no_match_q, no_match_d;
  logic        load_perr_q, load_perr_d;
  logic [5:0]  par_cnt_q, par_cnt_d;

  logic        match_valid;
  logic [3:0]  match_idx;
  logic        perr;
  logic [7:0]  plain;
  logic        drop;

  lfsr_tap_matcher u_matcher (
    .state_buf_i   (sbuf_q),
    .match_valid_o (match_valid),
    .match_idx_o   (match_idx)
  );

`ifdef PARITY_CHECK_EN
  // Even parity: bit 7 must equal the XOR of the seven data bits.
  assign perr = rd_data[7] ^ (^rd_data[6:0]);
`else
  logic unused_parity_bit;
  assign unused_parity_bit = rd_data[7];
  assign perr              = 1'b0;
`endif

  assign plain = {1'b0, rd_data[6:0] ^ lfsr_q};
  assign drop  = strip_q && (plain == SPACE) && (strip_cnt_q < MAX_STRIP);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      sbuf_q      <= '0;
      lfsr_q      <= '0;
      ptrn_q      <= '0;
      strip_q     <= 1'b0;
      strip_cnt_q <= '0;
      wr_ptr_q    <= '0;
      no_match_q  <= 1'b0;
      load_perr_q <= 1'b0;
      par_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= Start;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      sbuf_q      <= sbuf_d;
      lfsr_q      <= lfsr_d;
      ptrn_q      <= ptrn_d;
      strip_q     <= strip_d;
      strip_cnt_q <= strip_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      no_match_q  <= no_match_d;
      load_perr_q <= load_perr_d;
      par_cnt_q   <= par_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    sbuf_d      = sbuf_q;
    lfsr_d      = lfsr_q;
    ptrn_d      = ptrn_q;
    strip_d     = strip_q;
    strip_cnt_d = strip_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    no_match_d  = no_match_q;
    load_perr_d = load_perr_q;
    par_cnt_d   = par_cnt_q;
    wr_en       = 1'b0;
    wr_addr     = 8'd0;
    wr_data     = 8'd0;

    case (state_q)
      ST_IDLE: begin
        if (start_q && !Start) begin
          state_d     = ST_LOAD;
          cnt_d       = 7'd0;
          rd_addr_d   = MSG_BASE;
          no_match_d  = 1'b0;
          load_perr_d = 1'b0;
          par_cnt_d   = 6'd0;
        end
      end

      // Cycle cnt issues byte cnt (0..7) and captures byte cnt-1 (1..8).
      ST_LOAD: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q < 7'd7) begin
          rd_addr_d = MSG_BASE + {1'b0, cnt_q} + 8'd1;
        end
        for (int i = 0; i < 8; i++) begin
          if (cnt_q == 7'(i + 1)) begin
            sbuf_d[i*7 +: 7] = rd_data[6:0] ^ SPACE[6:0];
          end
        end
        if ((cnt_q != 7'd0) && perr) begin
          load_perr_d = 1'b1;
        end
        if (cnt_q == 7'd8) begin
          state_d = ST_MATCH;
        end
      end

      ST_MATCH: begin
        if (match_valid && !load_perr_q) begin
          state_d     = ST_DECODE;
          cnt_d       = 7'd0;
          rd_addr_d   = MSG_BASE;
          lfsr_d      = sbuf_q[6:0];
          strip_d     = 1'b1;
          strip_cnt_d = 6'd0;
          wr_ptr_d    = 7'd0;
          for (int i = 0; i < NUM_PTRN; i++) begin
            if (match_idx == 4'(i)) begin
              ptrn_d = LFSR_PTRN[i];
            end
          end
        end else begin
          no_match_d = 1'b1;
          state_d    = ST_DONE;
        end
      end

      // Cycle cnt issues byte cnt (0..63) and consumes byte cnt-1 (1..64).
      ST_DECODE: begin
        if (cnt_q != 7'd0) begin
          lfsr_d = lfsr_step(lfsr_q, ptrn_q);
          if (perr) begin
            strip_d = 1'b0;
            if (par_cnt_q != 6'h3F) begin
              par_cnt_d = par_cnt_q + 6'd1;
            end
            wr_en    = 1'b1;
            wr_addr  = OUT_BASE + {1'b0, wr_ptr_q};
            wr_data  = PERR_BYTE;
            wr_ptr_d = wr_ptr_q + 7'd1;
          end else if (drop) begin
            strip_cnt_d = strip_cnt_q + 6'd1;
          end else begin
            strip_d  = 1'b0;
            wr_en    = 1'b1;
            wr_addr  = OUT_BASE + {1'b0, wr_ptr_q};
            wr_data  = plain;
            wr_ptr_d = wr_ptr_q + 7'd1;
          end
        end
        if (cnt_q == 7'd64) begin
          if (wr_ptr_d == 7'd64) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_PAD;
          end
        end else begin
          cnt_d = cnt_q + 7'd1;
          if (cnt_q < 7'd63) begin
            rd_addr_d = MSG_BASE + {1'b0, cnt_q} + 8'd1;
          end
        end
      end

      ST_PAD: begin
        wr_en    = 1'b1;
        wr_addr  = OUT_BASE + {1'b0, wr_ptr_q};
        wr_data  = SPACE;
        wr_ptr_d = wr_ptr_q + 7'd1;
        if (wr_ptr_q == 7'd63) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (Start) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign Ack         = (state_q == ST_DONE);
  assign rd_addr     = rd_addr_q;
  assign no_match    = no_match_q;
  assign par_err_cnt = par_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_msg_decrypt_engine.sv
`timescale 1ns/1ps
module tb_msg_decrypt_engine;

  localparam int MSG_BASE = 64;
  localparam int OUT_BASE = 0;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ack, wr_en, no_match;
  logic [7:0] rd_addr, rd_data, wr_addr, wr_data;
  logic [5:0] par_err_cnt;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  msg_decrypt_engine dut (
    .Clk         (clk),
    .Reset       (rst),
    .Start       (start),
    .Ack         (ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .no_match    (no_match),
    .par_err_cnt (par_err_cnt),
    .dbg_state   (dbg_state)
  );

  // Encrypted message image (bench-written) and write-back image (DUT-written).
  logic [7:0] mem  [256];
  logic [7:0] wmem [256];

  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) wmem[wr_addr] <= wr_data;
  end

  // ---------------- scoreboard state ----------------
  int          tests_run = 0;
  int          fails     = 0;
  int          wr_seen   = 0;
  logic [15:0] exp_q[$];          // {addr, data} of each expected write, in order
  logic [7:0]  m_out [64];
  int          m_ack;
  int          m_par;
  logic        m_nm;
  logic [6:0]  pats [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every DUT write must be the next expected one.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", wr_addr, wr_data);
      end else begin
        check("write", {wr_addr, wr_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Plaintext = pre spaces + text + trailing spaces (64 bytes), XORed with the
  // LFSR stream and tagged with even parity in bit 7.
  task automatic encrypt(input logic [6:0] p, input logic [6:0] init, input int pre, input string text);
    logic [6:0] l;
    logic [7:0] pl, e;
    l = init;
    for (int i = 0; i < 64; i++) begin
      if (i >= pre && (i - pre) < text.len()) pl = text[i - pre];
      else pl = 8'h20;
      e[6:0] = pl[6:0] ^ l;
      e[7]   = ^e[6:0];
      mem[MSG_BASE + i] = e;
      l = {l[5:0], ^(l & p)};
    end
  endtask

  // Model: decrypt the image in mem straight from the rules.
  task automatic build_model();
    logic [6:0] s [8];
    logic [6:0] p, l;
    logic [7:0] b, pl;
    bit found, ok, bad_load, strip, perr;
    int sc, n;
    exp_q.delete();
    found = 0; bad_load = 0; p = 7'd0;
    for (int i = 0; i < 8; i++) begin
      b = mem[MSG_BASE + i];
      s[i] = b[6:0] ^ 7'h20;
`ifdef PARITY_CHECK_EN
      if (b[7] != ^b[6:0]) bad_load = 1;
`endif
    end
    for (int j = 0; j < 9; j++) begin
      ok = 1;
      for (int i = 0; i < 7; i++)
        if (s[i+1] != {s[i][5:0], ^(s[i] & pats[j])}) ok = 0;
      if (ok && !found) begin found = 1; p = pats[j]; end
    end
    m_par = 0;
    if (!found || bad_load) begin
      m_nm  = 1;
      m_ack = 10;
      return;
    end
    m_nm = 0;
    l = s[0]; strip = 1; sc = 0; n = 0;
    for (int i = 0; i < 64; i++) begin
      b  = mem[MSG_BASE + i];
      pl = {1'b0, b[6:0] ^ l};
      l  = {l[5:0], ^(l & p)};
      perr = 0;
`ifdef PARITY_CHECK_EN
      perr = (b[7] != ^b[6:0]);
`endif
      if (perr) begin
        if (m_par < 63) m_par++;
        strip = 0;
        m_out[n] = 8'h80; n++;
      end else if (strip && pl == 8'h20 && sc < 63) begin
        sc++;
      end else begin
        strip = 0;
        m_out[n] = pl; n++;
      end
    end
    while (n < 64) begin m_out[n] = 8'h20; n++; end
    m_ack = 75 + sc;
    for (int i = 0; i < 64; i++) exp_q.push_back({8'(OUT_BASE + i), m_out[i]});
  endtask

  task automatic launch();
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);   // launch edge; the next cycle is LOAD cycle 0
  endtask

  task automatic run_msg(input string name, output int ack_cyc);
    int bad;
    build_model();
    launch();
    ack_cyc = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (ack) begin ack_cyc = c; break; end
      @(posedge clk);
    end
    if (ack_cyc < 0) begin
      tests_run++;
      fails++;
      $display("FAIL %s ack_timeout: no Ack within 300 cycles, state %0d", name, dbg_state);
    end
    check({name, " ack_cycle"}, ack_cyc, m_ack);
    check({name, " no_match"}, no_match, m_nm);
    check({name, " par_err_cnt"}, par_err_cnt, m_par);
    check({name, " writes_missing"}, exp_q.size(), 0);
    if (!m_nm) begin
      bad = 0;
      for (int i = 0; i < 64; i++) if (wmem[OUT_BASE + i] !== m_out[i]) bad++;
      check({name, " out_bytes_wrong"}, bad, 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] saved [64];
  int ac, w0, bad2;

  initial begin
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; wmem[i] = 8'hEE; end
    repeat (3) @(posedge clk);
    #1;
    check("rst ack", ack, 0);
    check("rst wr_en", wr_en, 0);
    check("rst wr_addr", wr_addr, 0);
    check("rst wr_data", wr_data, 0);
    check("rst rd_addr", rd_addr, 0);
    check("rst no_match", no_match, 0);
    check("rst par_err_cnt", par_err_cnt, 0);
    @(negedge clk) rst = 1'b0;

    // "Hi", pattern 0x60, seed 0x01, 10-space preamble
    encrypt(7'h60, 7'h01, 10, "Hi");
    check("hi enc_byte0", mem[64], 8'h21);
    run_msg("hi", ac);
    check("hi ack_lit", ac, 85);
    check("hi out0", wmem[0], 8'h48);
    check("hi out1", wmem[1], 8'h69);
    check("hi out2", wmem[2], 8'h20);
    check("hi out63", wmem[63], 8'h20);
    for (int i = 0; i < 64; i++) saved[i] = wmem[i];

    // Start held low after DONE: no relaunch, no writes
    w0 = wr_seen;
    repeat (20) @(posedge clk);
    #1;
    check("held ack", ack, 1);
    check("held writes", wr_seen - w0, 0);

    // Start 1 then 0: identical second run
    for (int i = 0; i < 64; i++) wmem[i] = 8'hEE;
    run_msg("hi_again", ac);
    bad2 = 0;
    for (int i = 0; i < 64; i++) if (wmem[i] !== saved[i]) bad2++;
    check("hi_again same_output", bad2, 0);

    // Every pattern, seed 0x7F, 26-space preamble
    for (int j = 0; j < 9; j++) begin
      encrypt(pats[j], 7'h7F, 26, "Decrypt OK!");
      run_msg($sformatf("pat%0d", j), ac);
      check($sformatf("pat%0d ack_lit", j), ac, 101);
      check($sformatf("pat%0d out0", j), wmem[0], 8'h44);
      check($sformatf("pat%0d out10", j), wmem[10], 8'h21);
    end

    // Corrupted preamble
    encrypt(7'h60, 7'h01, 10, "Hi");
    mem[67] = 8'h00;
    w0 = wr_seen;
    run_msg("corrupt", ac);
    check("corrupt ack_lit", ac, 10);
    check("corrupt no_match_lit", no_match, 1);
    check("corrupt writes", wr_seen - w0, 0);

    // Parity error on message byte 40 (output position 30)
    encrypt(7'h60, 7'h01, 10, "Hi");
    mem[MSG_BASE + 40] = mem[MSG_BASE + 40] ^ 8'h80;
    run_msg("parity", ac);
`ifdef PARITY_CHECK_EN
    check("parity out30", wmem[30], 8'h80);
    check("parity cnt_lit", par_err_cnt, 1);
`else
    check("parity out30", wmem[30], 8'h20);
    check("parity cnt_lit", par_err_cnt, 0);
`endif

    // Strip limit: 64 spaces -> 63 dropped, one written, 63 pads
    encrypt(7'h48, 7'h05, 64, "");
    run_msg("all_space", ac);
    check("all_space ack_lit", ac, 138);
    check("all_space out0", wmem[0], 8'h20);

    // Text beginning with spaces loses them
    encrypt(7'h72, 7'h2A, 8, "  go");
    run_msg("lead_sp", ac);
    check("lead_sp ack_lit", ac, 85);
    check("lead_sp out0", wmem[0], 8'h67);
    check("lead_sp out1", wmem[1], 8'h6F);

    // Reset in the middle of DECODE (cycle 40)
    encrypt(7'h60, 7'h01, 10, "Hi");
    build_model();
    launch();
    repeat (40) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst ack", ack, 0);
    check("midrst wr_en", wr_en, 0);
    check("midrst no_match", no_match, 0);
    check("midrst rd_addr", rd_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    run_msg("after_rst", ac);
    check("after_rst ack_lit", ac, 85);
    check("after_rst out0", wmem[0], 8'h48);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/msg_decrypt_engine.md
# msg_decrypt_engine

Hardware decryptor for the programmable message-encryption flow. It reads a 64-byte encrypted, parity-tagged message from data memory and recovers the LFSR tap pattern and starting state from the known ASCII-space preamble. It then decrypts the message, strips the leading spaces, and writes the plaintext back to data memory. It sits beside the TopLevel core on the data-memory port and uses the same Start/Ack launch handshake as the encrypt program.

## Interface
- MSG_BASE, 64: data-memory address of encrypted byte 0 (bytes MSG_BASE..MSG_BASE+63).
- OUT_BASE, 0: address of plaintext byte 0 (bytes OUT_BASE..OUT_BASE+63).
- MAX_STRIP, 63: maximum number of leading 0x20 bytes removed.
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high; forces IDLE.
- Start  in  1  high holds the block in IDLE; a 1->0 transition launches a run.
- Ack  out  1  high in DONE; reset 0.
- rd_addr  out  8  memory read address, synchronous read, data valid the next cycle; reset 0.
- rd_data  in  8  read data.
- wr_en  out  1  memory write strobe; reset 0.
- wr_addr  out  8  write address; reset 0.
- wr_data  out  8  write data; reset 0.
- no_match  out  1  no tap pattern fits the preamble; sticky until the next launch; reset 0.
- par_err_cnt  out  6  count of parity-failing bytes, saturates at 63; reset 0.

## Operation
- States: IDLE, LOAD, MATCH, DECODE, PAD, DONE.
- IDLE: Start is registered. When the registered value is 1 and the current value is 0, the block clears no_match and par_err_cnt and enters LOAD.
- LOAD: issues MSG_BASE+0..7. Each returned byte gives s[i] = rd_data[6:0] ^ 7'h20, stored in an 8-entry state buffer.
- MATCH: tests the 9 patterns 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B in index order.
  - Pattern p fits when s[i+1] == {s[i][5:0], ^(s[i] & p)} for i = 0..6.
  - The lowest-index fit is selected and the LFSR is loaded with s[0].
  - If no pattern fits, no_match is set and the block goes directly to DONE with no writes.
- DECODE, for i = 0..63:
  - Issue MSG_BASE+i.
  - On data return, form plain = {1'b0, rd_data[6:0] ^ lfsr}, then advance lfsr = {lfsr[5:0], ^(lfsr & p)}.
  - While the strip flag is set, plain == 0x20, and the strip count is below MAX_STRIP, the byte is dropped and the strip count increments.
  - Otherwise the strip flag clears and plain is written at OUT_BASE+wr_ptr, then wr_ptr increments.
- PAD: writes 0x20 at OUT_BASE+wr_ptr until wr_ptr == 64. Exactly 64 plaintext bytes are always written.
- DONE: Ack = 1. Start going high returns the block to IDLE, with Ack falling the next cycle. A new launch requires another 1->0 transition.
- A message whose own text begins with spaces loses those spaces, up to MAX_STRIP. This is the defined behaviour.
- wr_ptr is 7 bits (0..64) and never wraps. Address arithmetic is 8-bit, and OUT_BASE+63 must not exceed 255.

## Timing
- Cycle 0 is the first LOAD cycle.
- LOAD: addresses issued in cycles 0..7, data captured in cycles 1..8.
- MATCH: cycle 9.
- DECODE: address MSG_BASE+i issued in cycle 10+i; write (if any) in cycle 11+i; DECODE spans cycles 10..74.
- PAD: k cycles, 75..74+k, where k = number of bytes stripped.
- Ack rises at cycle 75+k. With no match, Ack rises at cycle 10.
- A read and a write may occur in the same cycle; separate read and write ports are required.
- Reset at any point, including mid-DECODE: every output returns to its reset value immediately, state becomes IDLE, and partially written memory is left as is.
- Start rising during a run is ignored until DONE.

## Configuration
- PARITY_CHECK_EN defined:
  - Each DECODE byte with rd_data[7] != ^rd_data[6:0] increments par_err_cnt.
  - The written byte is replaced with 0x80, and the strip flag clears.
  - LOAD bytes failing parity cause no_match.
- Undefined: bit 7 is ignored and par_err_cnt is tied to 0.

## Structure
- Package msg_crypt_pkg holds:
  - the LFSR_PTRN[9] constant array;
  - SPACE = 8'h20;
  - the state enum;
  - the lfsr_step function.
- Sub-module lfsr_tap_matcher: a combinational block that takes the 8-entry state buffer and outputs match_valid plus a 4-bit pattern index.

## Test plan
- Pattern 0x60, init 0x01, 10-byte preamble, text "Hi" -> OUT bytes 0..1 = 0x48 0x69, bytes 2..63 = 0x20, Ack at cycle 85, no_match = 0. Encrypted byte 64 = 0x21.
- Each of the 9 patterns with init 0x7F and a 26-byte preamble -> correct plaintext, Ack at cycle 101, selected index matches.
- Preamble corrupted so byte 67 = 0x00 -> no_match = 1, no writes, Ack at cycle 10.
- PARITY_CHECK_EN defined, bit 7 of message byte 40 flipped -> OUT at that position = 0x80, par_err_cnt = 1. Undefined: plaintext correct, count 0.
- Reset asserted at cycle 40 -> Ack, wr_en, and no_match are 0 at once; a new Start 1->0 completes normally.
- Start held at 0 after DONE -> no relaunch. Start 1 then 0 -> second run yields identical output.
